pmod_mic_array: RTL and testbench

Parametrised multi-channel SPI capture for Pmod MIC-class ADCs (ADCS7476-style framing: leading zeros, then MSB-first sample). Drives one shared SCLK/CS pair to NUM_CH microphones, each with its own MISO line, and delivers all channels as one word under a valid/ready handshake. Frames start on a `read` pulse or from an internal sample-rate timer. Sits between the board pins and the audio processing chain; replaces the single-channel fixed-divider capture path.

---
 rtl/mic_array_pkg.sv | 25 ++
 rtl/spi_sclk_gen.sv | 51 +++++
 rtl/pmod_mic_array.sv | 158 +++++++++++++++
 tb/tb_pmod_mic_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mic_array_pkg.sv
// Shared types and defaults for the multi-channel Pmod MIC capture block.
package mic_array_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StQuiet
    } mic_state_e;

    localparam int unsigned DefNumCh       = 2;
    localparam int unsigned DefDataW       = 12;
    localparam int unsigned DefFrameBits   = 16;
    localparam int unsigned DefLeadZeros   = 4;
    localparam int unsigned DefClkDiv      = 8;
    localparam int unsigned DefCsIdleClks  = 8;
    localparam int unsigned DefSamplePer   = 2500;

    // Accepting cycle + setup half period + all SCLK periods.
    function automatic int unsigned frame_clks(input int unsigned clk_div,
                                               input int unsigned frame_bits);
        return 1 + clk_div / 2 + frame_bits * clk_div;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: high half (setup), then low/high halves; strobes mark the end of
// each low half (sample point) and each high half (period end).
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic last,
    output logic sclk,
    output logic sample_stb,
    output logic period_end
);
    localparam int unsigned Half = CLK_DIV / 2;
    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;
    logic            half_end;

    assign half_end   = en && (cnt_q == CntW'(Half - 1));
    assign sample_stb = half_end && !sclk_q;
    assign period_end = half_end && sclk_q;
    assign sclk       = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b1;
        end else if (half_end) begin
            cnt_d  = '0;
            // Final high half must not drop SCLK again before CS rises.
            sclk_d = !sclk_q || last;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/pmod_mic_array.sv
// Multi-channel SPI capture for ADCS7476-style microphones: shared SCLK/CS,
// per-channel MISO, all channels delivered as one word under valid/ready.
module pmod_mic_array
    import mic_array_pkg::*;
#(
    parameter int unsigned NUM_CH        = DefNumCh,
    parameter int unsigned DATA_W        = DefDataW,
    parameter int unsigned FRAME_BITS    = DefFrameBits,
    parameter int unsigned LEAD_ZEROS    = DefLeadZeros,
    parameter int unsigned CLK_DIV       = DefClkDiv,
    parameter int unsigned CS_IDLE_CLKS  = DefCsIdleClks,
    parameter int unsigned SAMPLE_PERIOD = DefSamplePer
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     read,
    input  logic [NUM_CH-1:0]        MISO,
    input  logic                     ready,
    input  logic                     overrun_clr,
    output logic                     SCLK,
    output logic                     CS,
    output logic [NUM_CH*DATA_W-1:0] audio,
    output logic                     new_data,
    output logic                     busy,
    output logic                     overrun
);
    localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
    localparam int unsigned QuietW = $clog2(CS_IDLE_CLKS + 1);
    localparam int unsigned MinPer = frame_clks(CLK_DIV, FRAME_BITS) + CS_IDLE_CLKS;
    // A shorter period could never be honoured, so clamp to the shortest usable one.
    localparam int unsigned Period = (SAMPLE_PERIOD < MinPer) ? MinPer : SAMPLE_PERIOD;
    localparam int unsigned TimerW = $clog2(Period + 1);

    mic_state_e          state_q, state_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [QuietW-1:0]   quiet_q, quiet_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                cs_q, busy_q, new_data_q, new_data_d, overrun_q, overrun_d;
    logic [NUM_CH*DATA_W-1:0] audio_q, frame_word;
    logic                tick, last_bit, frame_done, capture;
    logic                sclk_en, sample_stb, period_end;

    assign tick     = mode && (timer_q == TimerW'(Period - 1));
    assign sclk_en  = (state_q == StSetup) || (state_q == StShift);
    assign last_bit = (state_q == StShift) && (bit_cnt_q == BitW'(FRAME_BITS - 1));
    assign capture  = (state_q == StShift) && sample_stb
                      && (bit_cnt_q >= BitW'(LEAD_ZEROS))
                      && (bit_cnt_q < BitW'(LEAD_ZEROS + DATA_W));

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sclk_en),
        .last      (last_bit),
        .sclk      (SCLK),
        .sample_stb(sample_stb),
        .period_end(period_end)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] sr_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr_q <= '0;
            end else if (capture) begin
                sr_q <= (sr_q << 1) | DATA_W'(MISO[k]);
            end
        end
        assign frame_word[k*DATA_W +: DATA_W] = sr_q;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        quiet_d    = quiet_q;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (mode ? tick : read) state_d = StSetup;
            end
            StSetup: begin
                if (period_end) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (period_end) begin
                    if (last_bit) begin
                        state_d    = StQuiet;
                        quiet_d    = '0;
                        frame_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            StQuiet: begin
                if (quiet_q == QuietW'(CS_IDLE_CLKS - 1)) state_d = StIdle;
                else quiet_d = quiet_q + QuietW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (mode && !tick) timer_d = timer_q + TimerW'(1);
    end

    // Completion without a same-cycle handshake overwrites the pending word.
    always_comb begin
        new_data_d = new_data_q;
        overrun_d  = overrun_q;
        if (frame_done) begin
            new_data_d = 1'b1;
            if (new_data_q && !ready) overrun_d = 1'b1;
            else if (overrun_clr) overrun_d = 1'b0;
        end else begin
            if (new_data_q && ready) new_data_d = 1'b0;
            if (overrun_clr) overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            quiet_q    <= '0;
            timer_q    <= '0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            new_data_q <= 1'b0;
            overrun_q  <= 1'b0;
            audio_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            quiet_q    <= quiet_d;
            timer_q    <= timer_d;
            cs_q       <= !((state_d == StSetup) || (state_d == StShift));
            busy_q     <= (state_d != StIdle);
            new_data_q <= new_data_d;
            overrun_q  <= overrun_d;
            if (frame_done) audio_q <= frame_word;
        end
    end

    assign CS       = cs_q;
    assign busy     = busy_q;
    assign new_data = new_data_q;
    assign overrun  = overrun_q;
    assign audio    = audio_q;

endmodule

// File: tb/tb_pmod_mic_array.sv
// Bench for pmod_mic_array: ADC slave models, a timeline model checked every cycle,
// and directed scenarios with literal expectations.
module tb_pmod_mic_array;
    localparam int NC = 2, DW = 12, FB = 16, LZ = 4, CD = 8, Q = 8, P = 2500;
    localparam int H = CD / 2;
    localparam int F = H + FB * CD;      // accept edge -> completion edge
    localparam int NC2 = 4, DW2 = 8;

    logic clk = 1'b0;
    logic rst, mode, read, ready, overrun_clr;
    logic [NC-1:0] miso;
    logic sclk, cs, new_data, busy, overrun;
    logic [NC*DW-1:0] audio;

    logic read2, mode2, ready2, clr2;
    logic [NC2-1:0] miso2;
    logic sclk2, cs2, nd2, busy2, ovr2;
    logic [NC2*DW2-1:0] audio2;

    pmod_mic_array #(
        .NUM_CH(NC), .DATA_W(DW), .FRAME_BITS(FB), .LEAD_ZEROS(LZ), .CLK_DIV(CD),
        .CS_IDLE_CLKS(Q), .SAMPLE_PERIOD(P)
    ) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .read(read), .MISO(miso), .ready(ready),
        .overrun_clr(overrun_clr), .SCLK(sclk), .CS(cs), .audio(audio),
        .new_data(new_data), .busy(busy), .overrun(overrun)
    );

    pmod_mic_array #(
        .NUM_CH(NC2), .DATA_W(DW2), .FRAME_BITS(16), .LEAD_ZEROS(4), .CLK_DIV(4),
        .CS_IDLE_CLKS(8), .SAMPLE_PERIOD(2500)
    ) u_dut4 (
        .clk(clk), .rst(rst), .mode(mode2), .read(read2), .MISO(miso2), .ready(ready2),
        .overrun_clr(clr2), .SCLK(sclk2), .CS(cs2), .audio(audio2),
        .new_data(nd2), .busy(busy2), .overrun(ovr2)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC slave models: each SCLK fall while CS low presents the next bit, MSB first.
    logic [15:0] word [NC];
    logic [15:0] word2 [NC2];
    int fidx = 0, falls = 0, cs_falls = 0, fidx2 = 0, falls2 = 0;
    int fall_q[$];
    int rise2[$];

    always @(negedge cs) begin
        fidx = 0; falls = 0; miso = '0; cs_falls++; fall_q.push_back(cyc);
    end
    always @(negedge sclk) if (!cs) begin
        falls++;
        if (fidx < FB) for (int k = 0; k < NC; k++) miso[k] = word[k][15-fidx];
        fidx++;
    end
    always @(negedge cs2) begin
        fidx2 = 0; falls2 = 0; miso2 = '0; rise2.delete();
    end
    always @(negedge sclk2) if (!cs2) begin
        falls2++;
        if (fidx2 < 16) for (int k = 0; k < NC2; k++) miso2[k] = word2[k][15-fidx2];
        fidx2++;
    end
    always @(posedge sclk2) if (!cs2) rise2.push_back(cyc);

    // Timeline model: a frame accepted at edge t owns CS until t+F, busy until t+F+Q,
    // and the next start is possible from edge t+F+Q+1.
    int m_start = -1, m_run = 0;
    logic m_nd = 1'b0, m_ovr = 1'b0, m_done, m_tick, m_idle;
    logic [NC*DW-1:0] m_audio = '0, m_pend = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_start = -1; m_nd = 1'b0; m_ovr = 1'b0; m_audio = '0; m_run = 0;
        end else begin
            m_done = (m_start >= 0) && (cyc - m_start == F);
            if (m_done) begin
                if (m_nd && !ready) m_ovr = 1'b1;
                else if (overrun_clr) m_ovr = 1'b0;
                m_audio = m_pend;
                m_nd = 1'b1;
            end else begin
                if (m_nd && ready) m_nd = 1'b0;
                if (overrun_clr) m_ovr = 1'b0;
            end
            m_tick = mode && (m_run % P == P - 1);
            m_run = mode ? m_run + 1 : 0;
            m_idle = (m_start < 0) || (cyc - m_start >= F + Q + 1);
            if (m_idle && (mode ? m_tick : read)) begin
                m_start = cyc;
                for (int k = 0; k < NC; k++) m_pend[k*DW +: DW] = word[k][FB-1-LZ -: DW];
            end
        end
    end

    int d;
    logic [4:0] e_ctl;
    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            d = (m_start < 0) ? 1000000 : cyc - m_start;
            e_ctl[4] = (d >= F);
            e_ctl[3] = (d < H || d >= F) ? 1'b1 : (((d - H) % CD) >= H);
            e_ctl[2] = (d < F + Q);
            e_ctl[1] = m_nd;
            e_ctl[0] = m_ovr;
            check("cycle_ctl{cs,sclk,busy,nd,ovr}", {cs, sclk, busy, new_data, overrun}, e_ctl);
            check("cycle_audio", audio, m_audio);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    int t, n0;

    initial begin
        rst = 1'b1; mode = 1'b0; read = 1'b0; ready = 1'b0; overrun_clr = 1'b0;
        read2 = 1'b0; mode2 = 1'b0; ready2 = 1'b0; clr2 = 1'b0;
        miso = '0; miso2 = '0;
        word[0] = 16'h0A5C; word[1] = 16'h0FFF;
        word2[0] = 16'h0123; word2[1] = 16'h0AB0; word2[2] = 16'h0FF0; word2[3] = 16'h0C35;
        step(3);
        check("rst_cs", cs, 1); check("rst_sclk", sclk, 1); check("rst_audio", audio, 0);
        check("rst_new_data", new_data, 0); check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        step(2);

        // Triggered frame with default parameters.
        pulse_read(); t = cyc;
        check("trig_cs_low", cs, 0);
        step(131);
        check("trig_nd_early", new_data, 0); check("trig_cs_still_low", cs, 0);
        step(1);
        check("trig_nd", new_data, 1); check("trig_cs_high", cs, 1);
        check("trig_audio", audio, 24'hFFFA5C); check("trig_16_falls", falls, 16);
        ready = 1'b1; step(1);
        check("trig_handshake", new_data, 0);

        // read during SHIFT/QUIET ignored; read held over edges t+140 and t+141.
        wait_until(t + 200);
        pulse_read(); t = cyc; n0 = cs_falls;
        wait_until(t + 49); pulse_read();
        wait_until(t + 134); pulse_read();
        check("no_extra_frame", cs_falls, n0);
        wait_until(t + 139); read = 1'b1; step(2); read = 1'b0;
        check("accept_t141_cs", cs, 0); check("accept_t141_count", cs_falls, n0 + 1);
        wait_until(t + 141 + F + Q + 2);

        // Overrun: two frames with ready low.
        ready = 1'b0;
        word[0] = 16'h0123; word[1] = 16'h0789;
        pulse_read(); step(F + Q + 2);
        check("ovr_first_nd", new_data, 1); check("ovr_first_flag", overrun, 0);
        word[0] = 16'h0456; word[1] = 16'h0ABC;
        pulse_read(); step(F + Q + 2);
        check("ovr_audio", audio, 24'hABC456); check("ovr_nd", new_data, 1);
        check("ovr_flag", overrun, 1);
        overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0); check("ovr_clr_nd_kept", new_data, 1);
        ready = 1'b1; step(1); ready = 1'b0;
        check("ovr_drained", new_data, 0);

        // Handshake on the very completion edge: new word taken, no overrun.
        word[0] = 16'h0111; word[1] = 16'h0222;
        pulse_read(); step(F + Q + 2);
        word[0] = 16'h0333; word[1] = 16'h0444;
        pulse_read(); t = cyc;
        wait_until(t + F - 1); ready = 1'b1; step(1); ready = 1'b0;
        check("same_cycle_nd", new_data, 1); check("same_cycle_ovr", overrun, 0);
        check("same_cycle_audio", audio, 24'h444333);
        step(Q + 4);

        // Reset mid-SHIFT while a word is pending.
        word[0] = 16'h0321; word[1] = 16'h0654;
        pulse_read(); t = cyc;
        wait_until(t + 37);
        check("pre_rst_sclk_low", sclk, 0);
        rst = 1'b1; #1;
        check("midrst_cs", cs, 1); check("midrst_sclk", sclk, 1);
        check("midrst_nd", new_data, 0); check("midrst_busy", busy, 0);
        step(2); rst = 1'b0; step(2);
        pulse_read(); step(F + 1);
        check("post_rst_audio", audio, 24'h654321); check("post_rst_falls", falls, 16);
        check("post_rst_nd", new_data, 1); check("post_rst_ovr", overrun, 0);
        step(Q + 4);

        // Continuous mode.
        ready = 1'b1; fall_q.delete(); n0 = cyc;
        mode = 1'b1;
        step(4 * P + 200);
        mode = 1'b0;
        check("cont_frames", fall_q.size(), 4);
        if (fall_q.size() == 4) begin
            check("cont_first_start", fall_q[0], n0 + P);
            for (int i = 1; i < 4; i++) check("cont_spacing", fall_q[i] - fall_q[i-1], P);
        end
        check("cont_overrun", overrun, 0);
        step(10);

        // Four-channel, 8-bit, CLK_DIV=4 instance.
        read2 = 1'b1; @(negedge clk); read2 = 1'b0; t = cyc;
        check("p4_cs_low", cs2, 0);
        step(65);
        check("p4_nd_early", nd2, 0);
        step(1);
        check("p4_nd", nd2, 1); check("p4_audio", audio2, 32'hC3FFAB12);
        check("p4_falls", falls2, 16); check("p4_rises", rise2.size(), 16);
        if (rise2.size() >= 3) check("p4_sclk_period", rise2[2] - rise2[1], 4);
        step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
